// File: rtl/fft_mag_stream.sv
// fft_mag_stream: streaming |X|^2 of FFT bins with per-frame bin indexing.
// Ports: clk, reset (sync, active-high); in_re/in_im/in_sop/in_valid/in_ready
// input beats; out_data/out_index/out_last/out_valid/out_ready output beats;
// frame_err pulses on a mid-frame in_sop when FFT_MAG_FRAME_CHECK_EN is set.
module fft_mag_stream #(
  parameter int N    = 1024,
  parameter int W_IN = 32,
  parameter int W    = 2*W_IN+1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [W_IN-1:0]      in_re,
  input  logic [W_IN-1:0]      in_im,
  input  logic                 in_sop,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [W-1:0]         out_data,
  output logic [$clog2(N)-1:0] out_index,
  output logic                 out_last,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 frame_err
);

  localparam int IW = $clog2(N);
  localparam int SW = 2*W_IN;

  typedef enum logic {IDLE, STREAM} state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [IW-1:0]   beat_idx;
  logic            en, acc, take, beat_last, sop_restart;
  logic signed [SW-1:0] re_ext, im_ext;

  logic            s1_valid_q, s1_valid_d;
  logic [SW-1:0]   s1_re2_q, s1_re2_d;
  logic [SW-1:0]   s1_im2_q, s1_im2_d;
  logic [IW-1:0]   s1_idx_q, s1_idx_d;
  logic            s1_last_q, s1_last_d;

  logic            out_valid_q, out_valid_d;
  logic [W-1:0]    out_data_q, out_data_d;
  logic [IW-1:0]   out_index_q, out_index_d;
  logic            out_last_q, out_last_d;
  logic            frame_err_q, frame_err_d;

  always_comb begin
    en  = ~out_valid_q | out_ready;
    // beats offered while reset is high are never taken into the pipe
    acc = in_valid & en & ~reset;

    sop_restart = 1'b0;
`ifdef FFT_MAG_FRAME_CHECK_EN
    sop_restart = (state_q == STREAM) & in_sop;
`endif

    take     = 1'b0;
    beat_idx = idx_q;
    unique case (state_q)
      IDLE: begin
        take     = in_sop;
        beat_idx = '0;
      end
      STREAM: begin
        take     = 1'b1;
        beat_idx = sop_restart ? '0 : idx_q;
      end
    endcase
    beat_last = (beat_idx == IW'(N-1));

    state_d = state_q;
    idx_d   = idx_q;
    if (acc && take) begin
      state_d = beat_last ? IDLE : STREAM;
      idx_d   = beat_last ? '0 : beat_idx + IW'(1);
    end

    frame_err_d = acc & sop_restart;

    // sign-extend so the low 2*W_IN bits of the product are the exact square
    re_ext = {{W_IN{in_re[W_IN-1]}}, in_re};
    im_ext = {{W_IN{in_im[W_IN-1]}}, in_im};

    s1_valid_d  = s1_valid_q;
    s1_re2_d    = s1_re2_q;
    s1_im2_d    = s1_im2_q;
    s1_idx_d    = s1_idx_q;
    s1_last_d   = s1_last_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_index_d = out_index_q;
    out_last_d  = out_last_q;
    if (en) begin
      s1_valid_d  = acc & take;
      s1_re2_d    = SW'(re_ext * re_ext);
      s1_im2_d    = SW'(im_ext * im_ext);
      s1_idx_d    = beat_idx;
      s1_last_d   = beat_last;
      out_valid_d = s1_valid_q;
      out_data_d  = W'(s1_re2_q) + W'(s1_im2_q);
      out_index_d = s1_idx_q;
      out_last_d  = s1_last_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      s1_valid_q  <= 1'b0;
      s1_re2_q    <= '0;
      s1_im2_q    <= '0;
      s1_idx_q    <= '0;
      s1_last_q   <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_index_q <= '0;
      out_last_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      s1_valid_q  <= s1_valid_d;
      s1_re2_q    <= s1_re2_d;
      s1_im2_q    <= s1_im2_d;
      s1_idx_q    <= s1_idx_d;
      s1_last_q   <= s1_last_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_index_q <= out_index_d;
      out_last_q  <= out_last_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign in_ready  = en;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_index = out_index_q;
  assign out_last  = out_last_q;
  assign frame_err = frame_err_q;

endmodule

// File: tb/tb_fft_mag_stream.sv
// tb_fft_mag_stream: directed table + hand sequences for fft_mag_stream.
// Expectations adapt to whether FFT_MAG_FRAME_CHECK_EN is defined.
module tb_fft_mag_stream;
  localparam int N = 1024;
  localparam int W_IN = 32;
  localparam int W = 65;
  localparam int IW = 10;
`ifdef FFT_MAG_FRAME_CHECK_EN
  localparam bit FCHK = 1'b1;
`else
  localparam bit FCHK = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [W_IN-1:0] in_re = '0;
  logic [W_IN-1:0] in_im = '0;
  logic in_sop = 1'b0;
  logic in_valid = 1'b0;
  logic in_ready;
  logic [W-1:0] out_data;
  logic [IW-1:0] out_index;
  logic out_last;
  logic out_valid;
  logic out_ready = 1'b1;
  logic frame_err;

  int checks = 0;
  int failures = 0;

  fft_mag_stream #(.N(N), .W_IN(W_IN), .W(W)) dut (
    .clk(clk), .reset(reset),
    .in_re(in_re), .in_im(in_im),
    .in_sop(in_sop), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_index(out_index), .out_last(out_last),
    .out_valid(out_valid), .out_ready(out_ready),
    .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic v, sop, ordy;
    logic [31:0] re, im;
    logic e_rdy, e_ov;
    logic [64:0] e_data;
    logic [9:0] e_idx;
    logic e_last;
  } vec_t;

  vec_t tv [9];

  task automatic chk(input string name, input logic [64:0] act,
                     input logic [64:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic sop,
                       input logic [31:0] re, input logic [31:0] im);
    in_valid = v;
    in_sop = sop;
    in_re = re;
    in_im = im;
  endtask

  task automatic do_reset;
    reset = 1'b1;
    out_ready = 1'b1;
    drive(1'b1, 1'b1, 32'd9, 32'd9);
    tick;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_index", out_index, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_frame_err", frame_err, 0);
    chk("rst_in_ready", in_ready, 1);
    tick;
    reset = 1'b0;
    drive(1'b0, 1'b0, 0, 0);
    tick;
    tick;
    chk("rst_drop", out_valid, 0);
  endtask

  initial begin
    int ntx, nrx, stalls, fe_cnt, j;
    logic stall;

    tv[0] = '{1, 1, 1, 32'd1, 32'd2, 1, 0, 65'd0, 10'd0, 0};
    tv[1] = '{1, 0, 1, 32'd3, -32'sd4, 1, 0, 65'd0, 10'd0, 0};
    tv[2] = '{1, 0, 1, -32'sd5, 32'd0, 1, 1, 65'd5, 10'd0, 0};
    tv[3] = '{1, 0, 0, 32'd0, 32'd0, 0, 1, 65'd25, 10'd1, 0};
    tv[4] = '{1, 0, 1, 32'd0, 32'd0, 1, 1, 65'd25, 10'd1, 0};
    tv[5] = '{1, 0, 1, 32'h80000000, 32'h80000000, 1, 1, 65'd25, 10'd2, 0};
    tv[6] = '{0, 0, 1, 32'd0, 32'd0, 1, 1, 65'd0, 10'd3, 0};
    tv[7] = '{0, 0, 1, 32'd0, 32'd0, 1, 1, 65'h8000000000000000, 10'd4, 0};
    tv[8] = '{0, 0, 1, 32'd0, 32'd0, 1, 0, 65'd0, 10'd0, 0};

    do_reset;
    for (int i = 0; i < 9; i++) begin
      drive(tv[i].v, tv[i].sop, tv[i].re, tv[i].im);
      out_ready = tv[i].ordy;
      #1;
      chk($sformatf("tv%0d_in_ready", i), in_ready, tv[i].e_rdy);
      chk($sformatf("tv%0d_out_valid", i), out_valid, tv[i].e_ov);
      if (tv[i].e_ov) begin
        chk($sformatf("tv%0d_data", i), out_data, tv[i].e_data);
        chk($sformatf("tv%0d_index", i), out_index, tv[i].e_idx);
        chk($sformatf("tv%0d_last", i), out_last, tv[i].e_last);
      end
      tick;
    end

    // full frame, re=3 im=-4
    do_reset;
    for (int k = 0; k <= 1025; k++) begin
      if (k < 1024) drive(1'b1, k == 0, 32'd3, -32'sd4);
      else drive(1'b0, 1'b0, 0, 0);
      tick;
      if (k == 0) chk("frame_first_lat", out_valid, 0);
      else if (k <= 1024) begin
        chk("frame_valid", out_valid, 1);
        chk("frame_data", out_data, 25);
        chk("frame_index", out_index, 65'(k-1));
        chk("frame_last", out_last, 65'(k-1 == 1023));
      end else chk("frame_end_valid", out_valid, 0);
    end

    // non-sop beats in IDLE are dropped, then a sop frame starts at 0
    for (int k = 0; k <= 9; k++) begin
      drive(1'b1, k == 5, 32'(k), 32'd0);
      tick;
      if (k <= 5) chk("nosop_drop", out_valid, 0);
      else begin
        chk("nosop_valid", out_valid, 1);
        chk("nosop_index", out_index, 65'(k-6));
        chk("nosop_data", out_data, 65'((k-1)*(k-1)));
      end
    end

    // backpressure at index 7
    do_reset;
    ntx = 0; nrx = 0; stalls = 0;
    for (int c = 0; c < 300 && nrx < 20; c++) begin
      stall = out_valid && out_index == 10'd7 && stalls < 3;
      if (stall) stalls++;
      out_ready = !stall;
      drive(ntx < 40, ntx == 0, 32'(ntx), 32'd0);
      #1;
      if (stall) begin
        chk("bp_in_ready", in_ready, 0);
        chk("bp_hold_data", out_data, 49);
        chk("bp_hold_index", out_index, 7);
      end
      if (in_valid && in_ready) ntx++;
      if (out_valid && out_ready) begin
        chk("bp_index", out_index, 65'(nrx));
        chk("bp_data", out_data, 65'(nrx*nrx));
        nrx++;
      end
      tick;
    end
    chk("bp_rx_count", 65'(nrx), 20);
    chk("bp_stall_count", 65'(stalls), 3);
    out_ready = 1'b1;

    // in_sop on beat index 100 inside a frame
    do_reset;
    fe_cnt = 0;
    for (int k = 0; k <= 106; k++) begin
      drive(k < 105, k == 0 || k == 100, 32'(k), 32'd0);
      tick;
      if (frame_err) fe_cnt++;
      chk("sop100_frame_err", frame_err, 65'(FCHK && k == 100));
      if (k >= 1 && k <= 105) begin
        j = k - 1;
        chk("sop100_valid", out_valid, 1);
        chk("sop100_index", out_index, 65'((FCHK && j >= 100) ? j-100 : j));
        chk("sop100_data", out_data, 65'(j*j));
      end
    end
    chk("sop100_err_pulses", 65'(fe_cnt), 65'(FCHK));

    // reset at index 500, then non-sop beats dropped until sop
    do_reset;
    for (int k = 0; k <= 512; k++) begin
      reset = (k == 500);
      drive(1'b1, k == 0 || k == 510, 32'(k), 32'd0);
      tick;
      if (k == 499) chk("rst500_pre_index", out_index, 498);
      if (k >= 500 && k <= 510) chk("rst500_drop", out_valid, 0);
      if (k >= 511) begin
        chk("rst500_valid", out_valid, 1);
        chk("rst500_index", out_index, 65'(k-511));
        chk("rst500_data", out_data, 65'((k-1)*(k-1)));
      end
    end
    reset = 1'b0;
    drive(1'b0, 1'b0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/fft_mag_stream.md
FFT_MAG_STREAM -- requirements
Module: fft_mag_stream

Interface
REQ-001 Parameter N, default 1024: FFT frame length in bins; power of two.
REQ-002 Parameter W_IN, default 32: width of the signed real and imaginary inputs.
REQ-003 Parameter W, default 2*W_IN+1 (65): output magnitude-squared width.
REQ-004 Port clk, input, 1: single clock; all logic is rising-edge.
REQ-005 Port reset, input, 1: synchronous, active-high reset.
REQ-006 Port in_re, input, W_IN: signed real part of the FFT bin.
REQ-007 Port in_im, input, W_IN: signed imaginary part of the FFT bin.
REQ-008 Port in_sop, input, 1: marks bin 0 of a frame; qualified by in_valid.
REQ-009 Port in_valid, input, 1: input beat valid.
REQ-010 Port in_ready, output, 1: block accepts the input beat this cycle.
REQ-011 Port out_data, output, W: unsigned re^2+im^2.
REQ-012 Port out_index, output, log2(N): bin index of out_data.
REQ-013 Port out_last, output, 1: high when out_index == N-1.
REQ-014 Port out_valid, output, 1: output beat valid.
REQ-015 Port out_ready, input, 1: consumer ready; a beat transfers when out_valid & out_ready.
REQ-016 Port frame_err, output, 1: one-cycle pulse on a framing error.

Function
REQ-017 An input beat SHALL be accepted when in_valid & in_ready.
REQ-018 Global enable en = ~out_valid | out_ready; in_ready SHALL equal en; all pipeline registers SHALL hold when en = 0.
REQ-019 The pipeline SHALL have exactly 2 stages: stage 1 registers re^2, im^2, index, last, and valid; stage 2 registers the sum to out_data, out_index, out_last, and out_valid.
REQ-020 Latency from accepted input to out_valid SHALL be 2 cycles when out_ready stays high, at a throughput of 1 beat/cycle.
REQ-021 Arithmetic: squares are unsigned 2*W_IN bits and the sum is zero-extended to W bits with no truncation or saturation; (-2^(W_IN-1))^2 is exact.
REQ-022 The FSM SHALL have two states: IDLE and STREAM.
REQ-023 In IDLE, accepted beats without in_sop SHALL be discarded (no output produced), and in_ready SHALL still follow REQ-018.
REQ-024 IDLE -> STREAM on an accepted beat with in_sop: that beat SHALL take index 0.
REQ-025 In STREAM, each accepted beat SHALL take the next index (previous + 1).
REQ-026 STREAM -> IDLE on acceptance of index N-1, which SHALL carry last = 1.
REQ-027 When IDLE receives an in_sop beat in the same cycle as an N-1 acceptance from the prior frame, the sop beat SHALL be index 0 of the new frame with no gap.
REQ-028 While out_valid & ~out_ready, out_data, out_index, and out_last SHALL remain stable.
REQ-029 The index SHALL never wrap past N-1 inside STREAM.

Reset
REQ-030 While reset is high, out_valid, stage-1 valid, out_last, and frame_err SHALL be 0; out_data and out_index SHALL be 0; the FSM SHALL be in IDLE; the index counter SHALL be 0.
REQ-031 Reset mid-frame SHALL discard all in-flight beats; after reset, output resumes only after a new in_sop.
REQ-032 in_ready SHALL be 1 during reset (because out_valid = 0), but beats presented during reset SHALL be dropped.

Configuration
REQ-033 Macro FFT_MAG_FRAME_CHECK_EN: when defined, an accepted in_sop in STREAM (any index other than the expected 0) SHALL pulse frame_err for 1 cycle and restart the frame, with that beat taking index 0; the partial previous frame's already-accepted beats still emerge unchanged.
REQ-034 When FFT_MAG_FRAME_CHECK_EN is undefined, frame_err SHALL be tied to 0, and in_sop in STREAM SHALL be ignored (the index continues incrementing).

Verification
REQ-035 Reset, then N=1024 beats with in_sop on the first, re=3, im=-4, out_ready=1: out_data=25 on every beat, indices 0..1023, out_last only at 1023, first out_valid 2 cycles after the first acceptance.
REQ-036 re=im=-2^31: out_data=2^63 (bit 63 set, bit 64 clear).
REQ-037 5 beats without sop, then a sop frame: no output for the first 5 beats; the first output has out_index=0.
REQ-038 out_ready low for 3 cycles at index 7: in_ready low; out_data and out_index=7 held stable; no beats lost or duplicated after release.
REQ-039 With FFT_MAG_FRAME_CHECK_EN, in_sop at the 100th beat: frame_err pulses once and that beat emerges with out_index=0; without the macro, it emerges with out_index=100 and frame_err=0.
REQ-040 reset asserted at index 500 for 1 cycle: out_valid=0 the next cycle; later non-sop beats are dropped until in_sop.
